// File: rtl/tl_xbar.sv
// TileLink-UL crossbar: NUM_M masters to NUM_S slaves plus an internal error responder.
// A is routed by address field, D by the master index carried in the widened source.

`ifndef TL_AW
`define TL_AW 32
`endif
`ifndef TL_DW
`define TL_DW 32
`endif
`ifndef TL_DBW
`define TL_DBW 4
`endif
`ifndef TL_SZW
`define TL_SZW 2
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif

// Round-robin arbiter with grant lock; one instance per destination (A) or per master (D).
module tl_rr_arb #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          ready,
   output logic          vld,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);
   logic [PW-1:0] ptr_q, lock_idx_q, pick, pick_hi, pick_lo;
   logic          locked_q, found_hi;

   // First requester above ptr wins; otherwise the lowest requester at or below ptr.
   always_comb begin
      found_hi = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[j]) begin
            if (PW'(j) > ptr_q) begin
               found_hi = 1'b1;
               pick_hi  = PW'(j);
            end else begin
               pick_lo = PW'(j);
            end
         end
      end
      pick = found_hi ? pick_hi : pick_lo;
      idx  = locked_q ? lock_idx_q : pick;
      vld  = locked_q ? req[lock_idx_q] : |req;
      gnt  = '0;
      for (int j = 0; j < N; j++)
         gnt[j] = vld && (idx == PW'(j));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= PW'(N - 1);
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
      end else if (vld && ready) begin
         ptr_q    <= idx;
         locked_q <= 1'b0;
      end else if (vld) begin
         locked_q   <= 1'b1;
         lock_idx_q <= idx;
      end
   end
endmodule

module tl_xbar #(
   parameter int NUM_M     = 2,
   parameter int NUM_S     = 2,
   parameter int SEL_LSB   = 12,
   parameter int SSEL_BITS = 2,
   parameter int MI_BITS   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
   parameter int SW        = `TL_SOURCE_BITS + MI_BITS
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_M-1:0]                       m_a_valid,
   output logic [NUM_M-1:0]                       m_a_ready,
   input  logic [NUM_M-1:0][2:0]                  m_a_opcode,
   input  logic [NUM_M-1:0][2:0]                  m_a_param,
   input  logic [NUM_M-1:0][`TL_SZW-1:0]          m_a_size,
   input  logic [NUM_M-1:0][`TL_SOURCE_BITS-1:0]  m_a_source,
   input  logic [NUM_M-1:0][`TL_AW-1:0]           m_a_address,
   input  logic [NUM_M-1:0][`TL_DBW-1:0]          m_a_mask,
   input  logic [NUM_M-1:0][`TL_DW-1:0]           m_a_data,
   output logic [NUM_M-1:0]                       m_d_valid,
   input  logic [NUM_M-1:0]                       m_d_ready,
   output logic [NUM_M-1:0][2:0]                  m_d_opcode,
   output logic [NUM_M-1:0][2:0]                  m_d_param,
   output logic [NUM_M-1:0][`TL_SZW-1:0]          m_d_size,
   output logic [NUM_M-1:0][`TL_SOURCE_BITS-1:0]  m_d_source,
   output logic [NUM_M-1:0][`TL_SINK_BITS-1:0]    m_d_sink,
   output logic [NUM_M-1:0]                       m_d_denied,
   output logic [NUM_M-1:0][`TL_DW-1:0]           m_d_data,
   output logic [NUM_S-1:0]                       s_a_valid,
   input  logic [NUM_S-1:0]                       s_a_ready,
   output logic [NUM_S-1:0][2:0]                  s_a_opcode,
   output logic [NUM_S-1:0][2:0]                  s_a_param,
   output logic [NUM_S-1:0][`TL_SZW-1:0]          s_a_size,
   output logic [NUM_S-1:0][SW-1:0]               s_a_source,
   output logic [NUM_S-1:0][`TL_AW-1:0]           s_a_address,
   output logic [NUM_S-1:0][`TL_DBW-1:0]          s_a_mask,
   output logic [NUM_S-1:0][`TL_DW-1:0]           s_a_data,
   input  logic [NUM_S-1:0]                       s_d_valid,
   output logic [NUM_S-1:0]                       s_d_ready,
   input  logic [NUM_S-1:0][2:0]                  s_d_opcode,
   input  logic [NUM_S-1:0][2:0]                  s_d_param,
   input  logic [NUM_S-1:0][`TL_SZW-1:0]          s_d_size,
   input  logic [NUM_S-1:0][SW-1:0]               s_d_source,
   input  logic [NUM_S-1:0][`TL_SINK_BITS-1:0]    s_d_sink,
   input  logic [NUM_S-1:0]                       s_d_denied,
   input  logic [NUM_S-1:0][`TL_DW-1:0]           s_d_data
);
   localparam int ND  = NUM_S + 1;   // destination NUM_S is the error responder
   localparam int DIW = $clog2(ND);

   typedef struct packed {
      logic [2:0]                 opcode;
      logic [2:0]                 param;
      logic [`TL_SZW-1:0]         size;
      logic [`TL_SOURCE_BITS-1:0] source;
      logic [`TL_AW-1:0]          address;
      logic [`TL_DBW-1:0]         mask;
      logic [`TL_DW-1:0]          data;
   } a_req_t;

   typedef struct packed {
      logic [2:0]               opcode;
      logic [2:0]               param;
      logic [`TL_SZW-1:0]       size;
      logic [SW-1:0]            source;
      logic [`TL_SINK_BITS-1:0] sink;
      logic                     denied;
      logic [`TL_DW-1:0]        data;
   } d_rsp_t;

   a_req_t [NUM_M-1:0]                m_a;
   logic   [NUM_M-1:0][DIW-1:0]       m_dst;
   logic   [ND-1:0][NUM_M-1:0]        a_req, a_gnt;
   logic   [ND-1:0][MI_BITS-1:0]      a_idx;
   logic   [ND-1:0]                   a_vld, a_dst_rdy;

   d_rsp_t [ND-1:0]                   d_src;
   logic   [ND-1:0]                   d_in_vld;
   logic   [NUM_M-1:0][ND-1:0]        d_req, d_gnt;
   logic   [NUM_M-1:0][DIW-1:0]       d_idx;
   logic   [NUM_M-1:0]                d_vld;

   logic                              err_vld_q, err_get_q, err_a_rdy, err_a_hs, err_d_hs;
   logic   [MI_BITS-1:0]              err_mi_q;
   logic   [`TL_SOURCE_BITS-1:0]      err_src_q;
   logic   [`TL_SZW-1:0]              err_size_q;
   logic   [SSEL_BITS-1:0]            sel;

   // Requests are masked by rst_n so every valid/ready output is 0 while reset is held.
   always_comb begin
      sel   = '0;
      a_req = '0;
      for (int k = 0; k < NUM_M; k++) begin
         m_a[k] = '{opcode: m_a_opcode[k], param: m_a_param[k], size: m_a_size[k],
                    source: m_a_source[k], address: m_a_address[k],
                    mask: m_a_mask[k], data: m_a_data[k]};
         sel      = m_a_address[k][SEL_LSB +: SSEL_BITS];
         m_dst[k] = (int'(sel) < NUM_S) ? DIW'(sel) : DIW'(NUM_S);
         for (int d = 0; d < ND; d++)
            a_req[d][k] = m_a_valid[k] && rst_n && (m_dst[k] == DIW'(d));
      end
   end

   for (genvar d = 0; d < ND; d++) begin : g_a_arb
      tl_rr_arb #(.N(NUM_M), .PW(MI_BITS)) u_arb (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (a_req[d]),
         .ready (a_dst_rdy[d]),
         .vld   (a_vld[d]),
         .gnt   (a_gnt[d]),
         .idx   (a_idx[d])
      );
      if (d < NUM_S) begin : g_slv
         assign a_dst_rdy[d] = s_a_ready[d];
      end else begin : g_err
         assign a_dst_rdy[d] = err_a_rdy;
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_S; j++) begin
         s_a_valid[j]   = a_vld[j];
         s_a_opcode[j]  = m_a[a_idx[j]].opcode;
         s_a_param[j]   = m_a[a_idx[j]].param;
         s_a_size[j]    = m_a[a_idx[j]].size;
         s_a_source[j]  = {a_idx[j], m_a[a_idx[j]].source};
         s_a_address[j] = m_a[a_idx[j]].address;
         s_a_mask[j]    = m_a[a_idx[j]].mask;
         s_a_data[j]    = m_a[a_idx[j]].data;
      end
      m_a_ready = '0;
      for (int k = 0; k < NUM_M; k++)
         for (int d = 0; d < ND; d++)
            m_a_ready[k] = m_a_ready[k] | (a_gnt[d][k] & a_dst_rdy[d]);
   end

   // Error responder: one entry, refillable in the cycle its response drains.
   assign err_a_hs  = a_vld[NUM_S] && err_a_rdy;
   assign err_a_rdy = !err_vld_q || err_d_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_vld_q  <= 1'b0;
         err_get_q  <= 1'b0;
         err_mi_q   <= '0;
         err_src_q  <= '0;
         err_size_q <= '0;
      end else if (err_a_hs) begin
         err_vld_q  <= 1'b1;
         err_get_q  <= (m_a[a_idx[NUM_S]].opcode == 3'd4);
         err_mi_q   <= a_idx[NUM_S];
         err_src_q  <= m_a[a_idx[NUM_S]].source;
         err_size_q <= m_a[a_idx[NUM_S]].size;
      end else if (err_d_hs) begin
         err_vld_q <= 1'b0;
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_S; j++) begin
         d_src[j] = '{opcode: s_d_opcode[j], param: s_d_param[j], size: s_d_size[j],
                      source: s_d_source[j], sink: s_d_sink[j],
                      denied: s_d_denied[j], data: s_d_data[j]};
         d_in_vld[j] = s_d_valid[j] && rst_n;
      end
      d_src[NUM_S] = '{opcode: err_get_q ? 3'd1 : 3'd0, param: 3'd0, size: err_size_q,
                       source: {err_mi_q, err_src_q}, sink: '0, denied: 1'b1, data: '0};
      d_in_vld[NUM_S] = err_vld_q;
      for (int i = 0; i < NUM_M; i++)
         for (int j = 0; j < ND; j++)
            d_req[i][j] = d_in_vld[j] && (d_src[j].source[SW-1 -: MI_BITS] == MI_BITS'(i));
   end

   for (genvar i = 0; i < NUM_M; i++) begin : g_d_arb
      tl_rr_arb #(.N(ND), .PW(DIW)) u_arb (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (d_req[i]),
         .ready (m_d_ready[i]),
         .vld   (d_vld[i]),
         .gnt   (d_gnt[i]),
         .idx   (d_idx[i])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         m_d_valid[i]  = d_vld[i];
         m_d_opcode[i] = d_src[d_idx[i]].opcode;
         m_d_param[i]  = d_src[d_idx[i]].param;
         m_d_size[i]   = d_src[d_idx[i]].size;
         m_d_source[i] = d_src[d_idx[i]].source[`TL_SOURCE_BITS-1:0];
         m_d_sink[i]   = d_src[d_idx[i]].sink;
         m_d_denied[i] = d_src[d_idx[i]].denied;
         m_d_data[i]   = d_src[d_idx[i]].data;
      end
      s_d_ready = '0;
      err_d_hs  = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         for (int j = 0; j < NUM_S; j++)
            s_d_ready[j] = s_d_ready[j] | (d_gnt[i][j] & m_d_ready[i]);
         err_d_hs = err_d_hs | (d_gnt[i][NUM_S] & m_d_ready[i]);
      end
   end
endmodule

// File: tb/tb_tl_xbar.sv
// Directed bench for tl_xbar: vector table for A routing/arbitration plus multi-cycle sequences.

`ifndef TL_AW
`define TL_AW 32
`endif
`ifndef TL_DW
`define TL_DW 32
`endif
`ifndef TL_DBW
`define TL_DBW 4
`endif
`ifndef TL_SZW
`define TL_SZW 2
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif

module tb_tl_xbar;
   localparam int NM = 2, NS = 2, SW = `TL_SOURCE_BITS + 1;

   logic clk = 1'b0, rst_n;
   logic [NM-1:0]                      m_a_valid, m_a_ready, m_d_valid, m_d_ready, m_d_denied;
   logic [NM-1:0][2:0]                 m_a_opcode, m_a_param, m_d_opcode, m_d_param;
   logic [NM-1:0][`TL_SZW-1:0]         m_a_size, m_d_size;
   logic [NM-1:0][`TL_SOURCE_BITS-1:0] m_a_source, m_d_source;
   logic [NM-1:0][`TL_AW-1:0]          m_a_address;
   logic [NM-1:0][`TL_DBW-1:0]         m_a_mask;
   logic [NM-1:0][`TL_DW-1:0]          m_a_data, m_d_data;
   logic [NM-1:0][`TL_SINK_BITS-1:0]   m_d_sink;
   logic [NS-1:0]                      s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_denied;
   logic [NS-1:0][2:0]                 s_a_opcode, s_a_param, s_d_opcode, s_d_param;
   logic [NS-1:0][`TL_SZW-1:0]         s_a_size, s_d_size;
   logic [NS-1:0][SW-1:0]              s_a_source, s_d_source;
   logic [NS-1:0][`TL_AW-1:0]          s_a_address;
   logic [NS-1:0][`TL_DBW-1:0]         s_a_mask;
   logic [NS-1:0][`TL_DW-1:0]          s_a_data, s_d_data;
   logic [NS-1:0][`TL_SINK_BITS-1:0]   s_d_sink;

   int total = 0, bad = 0;

   tl_xbar #(.NUM_M(NM), .NUM_S(NS), .SEL_LSB(12), .SSEL_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
      .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
      .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
      .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
      .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
      .m_d_sink(m_d_sink), .m_d_denied(m_d_denied), .m_d_data(m_d_data),
      .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
      .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
      .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
      .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
      .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
      .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mav;
      logic [31:0] a0, a1;
      logic [1:0]  sar;
      logic [1:0]  e_sav, e_mar;
      logic [8:0]  e_src0, e_src1;
   } vec_t;
   vec_t tv[11];
   logic [1:0] exp_gnt[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
      m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_d_ready = '0;
      s_a_ready = '0; s_d_valid = '0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
      s_d_source = '0; s_d_sink = '0; s_d_denied = '0; s_d_data = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // sources: M0 = 0x10, M1 = 0x21; S0 = address 0x0000, S1 = 0x1000
      tv[0]  = '{2'b00, 32'h0,    32'h0,    2'b11, 2'b00, 2'b00, 9'h000, 9'h000};
      tv[1]  = '{2'b01, 32'h1000, 32'h0,    2'b11, 2'b10, 2'b01, 9'h000, 9'h010};
      tv[2]  = '{2'b10, 32'h0,    32'h0,    2'b11, 2'b01, 2'b10, 9'h121, 9'h000};
      tv[3]  = '{2'b11, 32'h0,    32'h1000, 2'b11, 2'b11, 2'b11, 9'h010, 9'h121};
      tv[4]  = '{2'b11, 32'h0,    32'h0,    2'b01, 2'b01, 2'b10, 9'h121, 9'h000};
      tv[5]  = '{2'b11, 32'h0,    32'h0,    2'b01, 2'b01, 2'b01, 9'h010, 9'h000};
      tv[6]  = '{2'b10, 32'h0,    32'h0,    2'b01, 2'b01, 2'b10, 9'h121, 9'h000};
      tv[7]  = '{2'b10, 32'h0,    32'h0,    2'b00, 2'b01, 2'b00, 9'h121, 9'h000};
      tv[8]  = '{2'b11, 32'h0,    32'h0,    2'b00, 2'b01, 2'b00, 9'h121, 9'h000};
      tv[9]  = '{2'b11, 32'h0,    32'h0,    2'b01, 2'b01, 2'b10, 9'h121, 9'h000};
      tv[10] = '{2'b11, 32'h0,    32'h0,    2'b01, 2'b01, 2'b01, 9'h010, 9'h000};
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

      idle();
      rst_n = 1'b0;
      #2;
      chk("rst_s_a_valid", 64'(s_a_valid), 64'h0);
      chk("rst_m_a_ready", 64'(m_a_ready), 64'h0);
      chk("rst_m_d_valid", 64'(m_d_valid), 64'h0);
      chk("rst_s_d_ready", 64'(s_d_ready), 64'h0);
      #10 rst_n = 1'b1;
      tick();

      // ---- table: A routing, round-robin, lock ----
      m_a_source[0] = 8'h10; m_a_source[1] = 8'h21;
      for (int v = 0; v < 11; v++) begin
         m_a_valid = tv[v].mav;
         m_a_address[0] = tv[v].a0;
         m_a_address[1] = tv[v].a1;
         s_a_ready = tv[v].sar;
         #1;
         chk($sformatf("v%0d_s_a_valid", v), 64'(s_a_valid), 64'(tv[v].e_sav));
         chk($sformatf("v%0d_m_a_ready", v), 64'(m_a_ready), 64'(tv[v].e_mar));
         if (tv[v].e_sav[0]) chk($sformatf("v%0d_src0", v), 64'(s_a_source[0]), 64'(tv[v].e_src0));
         if (tv[v].e_sav[1]) chk($sformatf("v%0d_src1", v), 64'(s_a_source[1]), 64'(tv[v].e_src1));
         tick();
      end
      idle();

      // ---- single Get through S1 and its response ----
      do_reset();
      m_a_valid = 2'b01; m_a_opcode[0] = 3'd4; m_a_source[0] = 8'h5A;
      m_a_address[0] = 32'h0000_1000; m_a_size[0] = 2'd2; m_a_mask[0] = 4'hF;
      s_a_ready = 2'b10;
      #1;
      chk("get_s_a_valid", 64'(s_a_valid), 64'h2);
      chk("get_s_a_source", 64'(s_a_source[1]), 64'h05A);
      chk("get_s_a_opcode", 64'(s_a_opcode[1]), 64'h4);
      chk("get_s_a_addr", 64'(s_a_address[1]), 64'h1000);
      chk("get_m_a_ready", 64'(m_a_ready), 64'h1);
      tick();
      m_a_valid = 2'b00;
      s_d_valid = 2'b10; s_d_opcode[1] = 3'd1; s_d_source[1] = 9'h05A;
      s_d_data[1] = 32'hDEADBEEF; s_d_size[1] = 2'd2; m_d_ready = 2'b01;
      #1;
      chk("get_m_d_valid", 64'(m_d_valid), 64'h1);
      chk("get_m_d_opcode", 64'(m_d_opcode[0]), 64'h1);
      chk("get_m_d_data", 64'(m_d_data[0]), 64'hDEADBEEF);
      chk("get_m_d_source", 64'(m_d_source[0]), 64'h5A);
      chk("get_s_d_ready", 64'(s_d_ready), 64'h2);
      tick();
      idle();

      // ---- contention: both masters PutFull to S0 ----
      do_reset();
      m_a_valid = 2'b11; m_a_source[0] = 8'h10; m_a_source[1] = 8'h21;
      s_a_ready = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr%0d_m_a_ready", i), 64'(m_a_ready), 64'(exp_gnt[i]));
         chk($sformatf("rr%0d_src", i), 64'(s_a_source[0]),
             exp_gnt[i][1] ? 64'h121 : 64'h010);
         tick();
      end

      // ---- stall lock: M1 held on S0 while M0 also requests ----
      m_a_valid = 2'b10; m_a_data[1] = 32'h1111_2222; s_a_ready = 2'b00;
      #1;
      chk("stall_s_a_valid", 64'(s_a_valid), 64'h1);
      tick();
      m_a_valid = 2'b11; m_a_data[0] = 32'h3333_4444;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d_src", i), 64'(s_a_source[0]), 64'h121);
         chk($sformatf("stall%0d_data", i), 64'(s_a_data[0]), 64'h1111_2222);
         chk($sformatf("stall%0d_m_a_ready", i), 64'(m_a_ready), 64'h0);
         tick();
      end
      s_a_ready = 2'b01;
      #1;
      chk("stall_release", 64'(m_a_ready), 64'h2);
      tick();
      m_a_valid = 2'b01;
      #1;
      chk("stall_next_m0", 64'(m_a_ready), 64'h1);
      tick();
      idle();

      // ---- unmapped address to the error responder ----
      m_a_valid = 2'b01; m_a_opcode[0] = 3'd4; m_a_source[0] = 8'h33;
      m_a_address[0] = 32'h0000_3000; m_a_size[0] = 2'd2; m_d_ready = 2'b01;
      #1;
      chk("err_s_a_valid", 64'(s_a_valid), 64'h0);
      chk("err_m_a_ready", 64'(m_a_ready), 64'h1);
      chk("err_no_d_yet", 64'(m_d_valid), 64'h0);
      tick();
      m_a_opcode[0] = 3'd1; m_a_source[0] = 8'h44;
      #1;
      chk("err_get_valid", 64'(m_d_valid), 64'h1);
      chk("err_get_opcode", 64'(m_d_opcode[0]), 64'h1);
      chk("err_get_denied", 64'(m_d_denied[0]), 64'h1);
      chk("err_get_data", 64'(m_d_data[0]), 64'h0);
      chk("err_get_source", 64'(m_d_source[0]), 64'h33);
      chk("err_get_size", 64'(m_d_size[0]), 64'h2);
      chk("err_b2b_ready", 64'(m_a_ready), 64'h1);
      tick();
      m_d_ready = 2'b00;
      #1;
      chk("err_put_valid", 64'(m_d_valid), 64'h1);
      chk("err_put_opcode", 64'(m_d_opcode[0]), 64'h0);
      chk("err_put_denied", 64'(m_d_denied[0]), 64'h1);
      chk("err_put_source", 64'(m_d_source[0]), 64'h44);
      chk("err_full_ready", 64'(m_a_ready), 64'h0);
      m_a_valid = 2'b00; m_d_ready = 2'b01;
      tick();
      #1;
      chk("err_drained", 64'(m_d_valid), 64'h0);
      idle();

      // ---- D contention: S0 and S1 both respond to M0 ----
      s_d_valid = 2'b11;
      s_d_source[0] = 9'h011; s_d_data[0] = 32'hA0; s_d_opcode[0] = 3'd1;
      s_d_source[1] = 9'h012; s_d_data[1] = 32'hB1;
      m_d_ready = 2'b00;
      #1;
      chk("dc_m_d_valid", 64'(m_d_valid), 64'h1);
      chk("dc_first_data", 64'(m_d_data[0]), 64'hA0);
      chk("dc_hold_ready", 64'(s_d_ready), 64'h0);
      tick();
      chk("dc_stable_data", 64'(m_d_data[0]), 64'hA0);
      m_d_ready = 2'b01;
      #1;
      chk("dc_s0_ready", 64'(s_d_ready), 64'h1);
      tick();
      s_d_valid = 2'b10;
      #1;
      chk("dc_second_data", 64'(m_d_data[0]), 64'hB1);
      chk("dc_second_src", 64'(m_d_source[0]), 64'h12);
      chk("dc_s1_ready", 64'(s_d_ready), 64'h2);
      tick();
      s_d_valid = 2'b11; s_d_source[1] = 9'h112; m_d_ready = 2'b11;
      #1;
      chk("dpar_m_d_valid", 64'(m_d_valid), 64'h3);
      chk("dpar_s_d_ready", 64'(s_d_ready), 64'h3);
      chk("dpar_m1_source", 64'(m_d_source[1]), 64'h12);
      tick();
      idle();

      // ---- reset while S0 is stalled with M1 locked ----
      m_a_source[0] = 8'h10; m_a_source[1] = 8'h21;
      m_a_valid = 2'b10; s_a_ready = 2'b00;
      tick();
      m_a_valid = 2'b11;
      s_d_valid = 2'b01; s_d_source[0] = 9'h011; m_d_ready = 2'b01;
      #1;
      chk("mr_pre_s_a_valid", 64'(s_a_valid), 64'h1);
      chk("mr_pre_s_a_src", 64'(s_a_source[0]), 64'h121);
      chk("mr_pre_s_d_ready", 64'(s_d_ready), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mr_s_a_valid", 64'(s_a_valid), 64'h0);
      chk("mr_m_a_ready", 64'(m_a_ready), 64'h0);
      chk("mr_m_d_valid", 64'(m_d_valid), 64'h0);
      chk("mr_s_d_ready", 64'(s_d_ready), 64'h0);
      s_d_valid = 2'b00;
      rst_n = 1'b1;
      s_a_ready = 2'b01;
      #1;
      chk("mr_first_grant", 64'(m_a_ready), 64'h1);
      chk("mr_first_src", 64'(s_a_source[0]), 64'h010);
      tick();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
